// File: rtl/mult_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module      : mult_accumulator_if
// Description : Product-in / sum-out handshake bundle for mult_accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
interface mult_accumulator_if #(
    parameter int WIDTH = 8,
    parameter int ACCW  = 20,
    parameter int CW    = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [2*WIDTH-1:0]   prod;
    logic                 flush;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACCW-1:0]      acc_out;
    logic [CW-1:0]        beats;
    logic                 ovf;

    // Upstream multiplier driver plus downstream result consumer.
    modport master (
        output in_valid,
        output prod,
        output flush,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  acc_out,
        input  beats,
        input  ovf
    );

    modport slave (
        input  in_valid,
        input  prod,
        input  flush,
        input  out_ready,
        output in_ready,
        output out_valid,
        output acc_out,
        output beats,
        output ovf
    );
endinterface
`default_nettype wire

// File: rtl/mult_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : mult_accumulator
// Description : Sums LEN consecutive unsigned products into one result word,
//               with flush to close a partial block. Define MULT_ACC_SAT_EN
//               to clamp on overflow instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_accumulator #(
    parameter int WIDTH = 8,
    parameter int ACCW  = 20,
    parameter int LEN   = 4,
    parameter int CW    = 8
) (
    input  logic              clk,
    input  logic              rst,
    mult_accumulator_if.slave bus
);

    localparam int PW = 2 * WIDTH;

    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

    localparam logic [CW-1:0]   c_last_cnt = CW'(LEN - 1);
    localparam logic [ACCW-1:0] c_acc_max  = {ACCW{1'b1}};

    generate
        if (ACCW < PW) begin : g_bad_accw
            $error("mult_accumulator: ACCW must be at least 2*WIDTH");
        end
        if (LEN < 1) begin : g_bad_len
            $error("mult_accumulator: LEN must be at least 1");
        end
        if ((CW < 32) && ((64'd1 << CW) <= 64'(LEN))) begin : g_bad_cw
            $error("mult_accumulator: CW too narrow to count LEN beats");
        end
    endgenerate

    logic [0:0]      r_state;
    logic [0:0]      w_state_next;
    logic            w_in_ready;
    logic            w_out_valid;

    logic [ACCW-1:0] r_acc;
    logic [CW-1:0]   r_cnt;
    logic            r_ovf;
    logic [ACCW-1:0] r_acc_out;
    logic [CW-1:0]   r_beats;
    logic            r_ovf_out;

    logic            w_beat;
    logic [ACCW:0]   w_sum;
    logic            w_carry;
    logic [ACCW-1:0] w_acc_add;
    logic [CW-1:0]   w_cnt_inc;
    logic            w_block_end;
    logic [ACCW-1:0] w_fin_acc;
    logic [CW-1:0]   w_fin_cnt;
    logic            w_fin_ovf;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_ACCUM;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_ACCUM: if (w_block_end)   w_state_next = ST_HOLD;
            ST_HOLD:  if (bus.out_ready) w_state_next = ST_ACCUM;
            default:                     w_state_next = ST_ACCUM;
        endcase
    end

    // FSM: outputs
    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            ST_ACCUM: w_in_ready  = 1'b1;
            ST_HOLD:  w_out_valid = 1'b1;
            default:  w_in_ready  = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    assign w_beat = bus.in_valid & w_in_ready;

    always_comb begin
        w_sum     = {1'b0, r_acc} + {{(ACCW + 1 - PW){1'b0}}, bus.prod};
        w_carry   = w_sum[ACCW];
`ifdef MULT_ACC_SAT_EN
        // Once clamped, any further non-zero product carries again and re-clamps.
        w_acc_add = w_carry ? c_acc_max : w_sum[ACCW-1:0];
`else
        w_acc_add = w_sum[ACCW-1:0];
`endif
        w_cnt_inc = r_cnt + CW'(1);
    end

    // A flush with nothing accumulated and no beat is not a block end.
    assign w_block_end = w_in_ready &
                         ((w_beat & (r_cnt == c_last_cnt)) |
                          (bus.flush & (w_beat | (r_cnt != '0))));

    // The result always includes a beat accepted on the closing edge.
    always_comb begin
        w_fin_acc = r_acc;
        w_fin_cnt = r_cnt;
        w_fin_ovf = r_ovf;
        if (w_beat) begin
            w_fin_acc = w_acc_add;
            w_fin_cnt = w_cnt_inc;
            w_fin_ovf = r_ovf | w_carry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
            r_acc_out <= '0;
            r_beats   <= '0;
            r_ovf_out <= 1'b0;
        end else if (w_block_end) begin
            r_acc_out <= w_fin_acc;
            r_beats   <= w_fin_cnt;
            r_ovf_out <= w_fin_ovf;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
        end else if (w_beat) begin
            r_acc     <= w_acc_add;
            r_cnt     <= w_cnt_inc;
            r_ovf     <= r_ovf | w_carry;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.acc_out   = r_acc_out;
    assign bus.beats     = r_beats;
    assign bus.ovf       = r_ovf_out;

endmodule
`default_nettype wire

// File: tb/tb_mult_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_accumulator
// Description : Two accumulator configurations driven in lockstep, checked
//               against a per-block arithmetic model through result queues.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_accumulator;

    localparam int WIDTH  = 8;
    localparam int CW     = 8;
    localparam int ACCW_A = 18;
    localparam int LEN_A  = 4;
    localparam int ACCW_B = 16;
    localparam int LEN_B  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iv = 1'b0;
    logic        fl = 1'b0;
    logic        ordy = 1'b0;
    logic [15:0] pr = '0;

    mult_accumulator_if #(.WIDTH(WIDTH), .ACCW(ACCW_A), .CW(CW)) bus_a ();
    mult_accumulator_if #(.WIDTH(WIDTH), .ACCW(ACCW_B), .CW(CW)) bus_b ();

    assign bus_a.in_valid  = iv;
    assign bus_a.prod      = pr;
    assign bus_a.flush     = fl;
    assign bus_a.out_ready = ordy;
    assign bus_b.in_valid  = iv;
    assign bus_b.prod      = pr;
    assign bus_b.flush     = fl;
    assign bus_b.out_ready = ordy;

    mult_accumulator #(.WIDTH(WIDTH), .ACCW(ACCW_A), .LEN(LEN_A), .CW(CW)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    mult_accumulator #(.WIDTH(WIDTH), .ACCW(ACCW_B), .LEN(LEN_B), .CW(CW)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint acc;
        int     beats;
        bit     ovf;
    } res_t;

    res_t   qa[$];
    res_t   qb[$];
    longint m_acc  [2];
    int     m_cnt  [2];
    bit     m_ovf  [2];
    bit     m_hold [2];
    int     n_checks = 0;
    int     n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input longint exp);
        n_checks++;
        if (act !== 64'(exp)) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint acc_mask(input int k);
        return (k == 0) ? ((64'd1 << ACCW_A) - 1) : ((64'd1 << ACCW_B) - 1);
    endfunction

    function automatic int blk_len(input int k);
        return (k == 0) ? LEN_A : LEN_B;
    endfunction

    // Block-level model: running total, clamped or wrapped on overflow.
    task automatic model_step(input int k);
        longint mask = acc_mask(k);
        res_t   r;
        if (m_hold[k]) begin
            if (ordy) m_hold[k] = 1'b0;
            return;
        end
        if (iv) begin
            m_acc[k] = m_acc[k] + longint'(pr);
            m_cnt[k] = m_cnt[k] + 1;
            if (m_acc[k] > mask) begin
                m_ovf[k] = 1'b1;
`ifdef MULT_ACC_SAT_EN
                m_acc[k] = mask;
`else
                m_acc[k] = m_acc[k] - (mask + 1);
`endif
            end
        end
        if ((iv && m_cnt[k] == blk_len(k)) || (fl && m_cnt[k] > 0)) begin
            r.acc   = m_acc[k];
            r.beats = m_cnt[k];
            r.ovf   = m_ovf[k];
            if (k == 0) qa.push_back(r);
            else        qb.push_back(r);
            m_acc[k]  = 0;
            m_cnt[k]  = 0;
            m_ovf[k]  = 1'b0;
            m_hold[k] = 1'b1;
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_acc[k]  = 0;
            m_cnt[k]  = 0;
            m_ovf[k]  = 1'b0;
            m_hold[k] = 1'b0;
        end
        qa.delete();
        qb.delete();
    endtask

    // Called just after a falling edge; returns at the next falling edge.
    task automatic cycle(input logic v, input logic [15:0] p, input logic f, input logic o);
        chk("in_ready_a", 64'(bus_a.in_ready), longint'(!m_hold[0]));
        chk("in_ready_b", 64'(bus_b.in_ready), longint'(!m_hold[1]));
        iv   = v;
        pr   = p;
        fl   = f;
        ordy = o;
        model_step(0);
        model_step(1);
        @(negedge clk);
    endtask

    task automatic check_res(input int k, input logic [63:0] acc, input logic [63:0] bts,
                             input logic [63:0] ov);
        res_t e;
        if ((k == 0 && qa.size() == 0) || (k == 1 && qb.size() == 0)) begin
            n_checks++;
            n_fail++;
            $display("FAIL result_%0d unexpected: queue empty, got acc %0h beats %0d", k, acc, bts);
            return;
        end
        e = (k == 0) ? qa.pop_front() : qb.pop_front();
        chk((k == 0) ? "sb_acc_a"   : "sb_acc_b",   acc, e.acc);
        chk((k == 0) ? "sb_beats_a" : "sb_beats_b", bts, longint'(e.beats));
        chk((k == 0) ? "sb_ovf_a"   : "sb_ovf_b",   ov,  longint'(e.ovf));
        n_checks++;
        if (bts == 0 || bts > 64'(blk_len(k))) begin
            n_fail++;
            $display("FAIL beats_range_%0d: got %0d, required 1..%0d", k, bts, blk_len(k));
        end
    endtask

    // Monitor: a handshake happens at the next rising edge when both are high.
    always begin
        @(negedge clk);
        #1;
        if (!rst) begin
            if (bus_a.out_valid && bus_a.out_ready)
                check_res(0, 64'(bus_a.acc_out), 64'(bus_a.beats), 64'(bus_a.ovf));
            if (bus_b.out_valid && bus_b.out_ready)
                check_res(1, 64'(bus_b.acc_out), 64'(bus_b.beats), 64'(bus_b.ovf));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_out_valid_a", 64'(bus_a.out_valid), 0);
        chk("rst_in_ready_a",  64'(bus_a.in_ready),  1);
        chk("rst_acc_out_a",   64'(bus_a.acc_out),   0);
        chk("rst_beats_a",     64'(bus_a.beats),     0);
        chk("rst_ovf_a",       64'(bus_a.ovf),       0);
        rst = 1'b0;

        // Full block on A; B (LEN=2, 16-bit) overflows on the same products.
        cycle(1'b1, 16'hFE01, 1'b0, 1'b1);
        cycle(1'b1, 16'hFE01, 1'b0, 1'b1);
        chk("ovf_out_valid_b", 64'(bus_b.out_valid), 1);
`ifdef MULT_ACC_SAT_EN
        chk("ovf_acc_b", 64'(bus_b.acc_out), 64'hFFFF);
`else
        chk("ovf_acc_b", 64'(bus_b.acc_out), 64'hFC02);
`endif
        chk("ovf_flag_b", 64'(bus_b.ovf), 1);
        cycle(1'b1, 16'hFE01, 1'b0, 1'b1);
        cycle(1'b1, 16'hFE01, 1'b0, 1'b1);
        chk("full_out_valid_a", 64'(bus_a.out_valid), 1);
        chk("full_acc_a",       64'(bus_a.acc_out),   64'h3F804);
        chk("full_beats_a",     64'(bus_a.beats),     4);
        chk("full_ovf_a",       64'(bus_a.ovf),       0);
        cycle(1'b0, 16'h0000, 1'b0, 1'b1);
        chk("full_one_cycle_a", 64'(bus_a.out_valid), 0);

        // Backpressure: result held, nothing accepted.
        for (int i = 0; i < 4; i++) cycle(1'b1, 16'hFE01, 1'b0, 1'b0);
        chk("bp_latency_a", 64'(bus_a.out_valid), 1);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 16'h1234, 1'b0, 1'b0);
            chk("bp_in_ready_a",  64'(bus_a.in_ready),  0);
            chk("bp_out_valid_a", 64'(bus_a.out_valid), 1);
            chk("bp_acc_a",       64'(bus_a.acc_out),   64'h3F804);
            chk("bp_beats_a",     64'(bus_a.beats),     4);
        end
        cycle(1'b0, 16'h0000, 1'b0, 1'b1);
        chk("bp_release_a", 64'(bus_a.in_ready), 1);

        // Flush with a same-cycle beat, then an empty flush.
        cycle(1'b1, 16'h0010, 1'b0, 1'b1);
        cycle(1'b1, 16'h0020, 1'b0, 1'b1);
        cycle(1'b1, 16'h0003, 1'b1, 1'b1);
        chk("flush_out_valid_a", 64'(bus_a.out_valid), 1);
        chk("flush_acc_a",       64'(bus_a.acc_out),   64'h33);
        chk("flush_beats_a",     64'(bus_a.beats),     3);
        cycle(1'b0, 16'h0000, 1'b1, 1'b1);
        cycle(1'b0, 16'h0000, 1'b1, 1'b1);
        chk("empty_flush_a", 64'(bus_a.out_valid), 0);
        cycle(1'b0, 16'h0000, 1'b0, 1'b1);
        chk("empty_flush2_a", 64'(bus_a.out_valid), 0);

        // Asynchronous reset between edges, mid-block.
        cycle(1'b1, 16'h0001, 1'b0, 1'b1);
        cycle(1'b1, 16'h0001, 1'b0, 1'b1);
        #2;
        iv  = 1'b0;
        fl  = 1'b0;
        rst = 1'b1;
        #1;
        chk("arst_acc_a",       64'(bus_a.acc_out),   0);
        chk("arst_beats_a",     64'(bus_a.beats),     0);
        chk("arst_out_valid_a", 64'(bus_a.out_valid), 0);
        chk("arst_in_ready_a",  64'(bus_a.in_ready),  1);
        chk("arst_out_valid_b", 64'(bus_b.out_valid), 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) cycle(1'b1, 16'h0001, 1'b0, 1'b1);
        chk("post_rst_valid_a", 64'(bus_a.out_valid), 1);
        chk("post_rst_acc_a",   64'(bus_a.acc_out),   4);
        chk("post_rst_beats_a", 64'(bus_a.beats),     4);

        // Randomized traffic.
        for (int i = 0; i < 1000; i++) begin
            logic [15:0] p;
            p = ($urandom_range(0, 3) == 0) ? 16'hFE01 : 16'($urandom());
            cycle($urandom_range(0, 3) != 0, p,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0);
        end

        repeat (6) cycle(1'b0, 16'h0000, 1'b0, 1'b1);
        chk("drained_a", 64'(qa.size()), 0);
        chk("drained_b", 64'(qb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
